cpu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 16-bit CPU core.
- Fixed 16-bit instruction, DATA_W-bit datapath and 8-entry register file.
- One shared memory port, used for instruction fetch and for load/store, with a req/ack handshake so memory latency is arbitrary.
- Adds load/store, conditional branch, CMP and HALT. The condition-code register holds its value between flag-setting instructions.

---
 rtl/cpu_mc_pkg.sv | 78 +++++++
 rtl/cpu_mc_alu.sv | 53 +++++
 rtl/cpu_mc.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_mc.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mc_pkg
// Purpose  : Opcodes, condition codes, FSM states and instruction field
//            positions shared by the multi-cycle 16-bit-ISA core.
// Revision : 1.0  initial release
// ============================================================================
package cpu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BR   = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_NE = 4'h2;
    localparam logic [3:0] CC_LT = 4'h3;
    localparam logic [3:0] CC_GE = 4'h4;
    localparam logic [3:0] CC_CS = 4'h5;
    localparam logic [3:0] CC_CC = 4'h6;
    localparam logic [3:0] CC_MI = 4'h7;

    localparam int F_OP_LSB   = 12;
    localparam int F_RD_LSB   = 9;
    localparam int F_RA_LSB   = 6;
    localparam int F_RB_LSB   = 3;
    localparam int F_COND_LSB = 8;
    localparam int F_IMM6_W   = 6;
    localparam int F_IMM9_W   = 9;
    localparam int F_OFF8_W   = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    // Codes 8..F fall through to "never", turning the branch into a no-op.
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            CC_AL:   cond_true = 1'b1;
            CC_EQ:   cond_true = z;
            CC_NE:   cond_true = ~z;
            CC_LT:   cond_true = (n != v);
            CC_GE:   cond_true = (n == v);
            CC_CS:   cond_true = c;
            CC_CC:   cond_true = ~c;
            CC_MI:   cond_true = n;
            default: cond_true = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mc_alu
// Purpose  : Combinational ALU producing a DATA_W result and NZCV flags.
// Revision : 1.0  initial release
// ============================================================================
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        nzcv
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic            c;
    logic            v;

    always_comb begin
        sum    = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[MSB:0];
                c      = sum[DATA_W];
                v      = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                // a + ~b + 1: the carry out is the inverted borrow.
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result = sum[MSB:0];
                c      = sum[DATA_W];
                v      = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
        nzcv = {result[MSB], (result == '0), c, v};
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mc
// Purpose  : Multi-cycle core, 16-bit ISA, one shared req/ack memory port.
// Revision : 1.0  initial release
// ============================================================================
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              RESET,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        cc_out,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        cc_q, cc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic [3:0]        op;
    logic [2:0]        rd, ra, rb;
    logic [3:0]        cond;
    logic [7:0]        off8;
    logic [DATA_W-1:0] imm6_sext, imm9_sext;
    logic [DATA_W-1:0] a_val, b_val, alu_b, alu_result;
    logic [3:0]        alu_nzcv;
    alu_op_e           alu_op;
    logic [ADDR_W-1:0] ra_addr, pc_plus2, br_target;
    logic              xfer;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    assign op   = ir_q[F_OP_LSB +: 4];
    assign rd   = ir_q[F_RD_LSB +: 3];
    assign ra   = ir_q[F_RA_LSB +: 3];
    assign rb   = ir_q[F_RB_LSB +: 3];
    assign cond = ir_q[F_COND_LSB +: 4];
    assign off8 = ir_q[F_OFF8_W-1:0];

    assign imm6_sext = {{(DATA_W-F_IMM6_W){ir_q[F_IMM6_W-1]}}, ir_q[F_IMM6_W-1:0]};
    assign imm9_sext = {{(DATA_W-F_IMM9_W){ir_q[F_IMM9_W-1]}}, ir_q[F_IMM9_W-1:0]};

    assign a_val = regs_q[ra];
    assign b_val = regs_q[rb];
    assign alu_b = (op == OP_ADDI) ? imm6_sext : b_val;

    assign pc_plus2  = pc_q + PC_STEP;
    assign br_target = pc_plus2 + {{(ADDR_W-F_OFF8_W-1){off8[7]}}, off8, 1'b0};
    assign xfer      = mem_req & mem_ack;

    generate
        if (DATA_W >= ADDR_W) begin : g_addr_trunc
            assign ra_addr = a_val[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign ra_addr = {{(ADDR_W-DATA_W){1'b0}}, a_val};
        end
    endgenerate

    always_comb begin
        case (op)
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_AND:         alu_op = ALU_AND;
            OP_OR:          alu_op = ALU_OR;
            OP_XOR:         alu_op = ALU_XOR;
            default:        alu_op = ALU_ADD;
        endcase
    end

    cpu_mc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .nzcv   (alu_nzcv)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (xfer) state_d = EXEC;
            EXEC: begin
                case (op)
                    OP_LD, OP_ST: state_d = MEM;
                    OP_HALT:      state_d = HALT;
                    default:      state_d = FETCH;
                endcase
            end
            MEM:     if (xfer) state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // The request is masked by RESET directly so it drops without waiting for a clock.
    always_comb begin
        mem_req   = ((state_q == FETCH) || (state_q == MEM)) && !RESET;
        mem_we    = (state_q == MEM) && (op == OP_ST);
        mem_addr  = (state_q == MEM) ? ra_addr : pc_q;
        mem_wdata = mem_we ? b_val : '0;
        halted    = (state_q == HALT);
        pc_out    = pc_q;
        cc_out    = cc_q;
    end

    always_comb begin
        pc_d     = pc_q;
        cc_d     = cc_q;
        ir_d     = ir_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (state_q)
            FETCH: if (xfer) ir_d = mem_rdata[15:0];
            EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_result;
                        cc_d     = alu_nzcv;
                        pc_d     = pc_plus2;
                    end
                    OP_CMP: begin
                        cc_d = alu_nzcv;
                        pc_d = pc_plus2;
                    end
                    OP_MOV: begin
                        rf_we    = 1'b1;
                        rf_wdata = b_val;
                        pc_d     = pc_plus2;
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm9_sext;
                        pc_d     = pc_plus2;
                    end
                    OP_BR:               pc_d = cond_true(cond, cc_q) ? br_target : pc_plus2;
                    OP_LD, OP_ST, OP_HALT: pc_d = pc_q;
                    default:             pc_d = pc_plus2;
                endcase
            end
            MEM: begin
                if (xfer) begin
                    pc_d = pc_plus2;
                    if (op == OP_LD) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = (rf_we && (rd == 3'(i))) ? rf_wdata : regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pc_q <= PC_INIT;
            cc_q <= 4'b0000;
            ir_q <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            cc_q <= cc_d;
            ir_q <= ir_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mc
// Purpose  : Directed + random program bench for cpu_mc with an instruction-
//            level reference model and a randomly-delayed memory responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_mc;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [3:0]  cc_out;

    cpu_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(0)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc_out    (pc_out),
        .cc_out    (cc_out),
        .halted    (halted)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          cyc;
        int          wt;
        logic [15:0] pc;
        logic [3:0]  cc;
        logic        hlt;
    } txn_t;

    logic [15:0] mem [logic [15:0]];
    txn_t        txq [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          max_wait = 0;
    int          force_wait = -1;
    logic [15:0] wp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: random wait per transfer, random ack noise when idle.
    bit          in_txn = 1'b0;
    int          wait_left, wt_now;
    logic        h_we;
    logic [15:0] h_addr, h_wdata;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (RESET || !mem_req) begin
                in_txn    = 1'b0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
            end else begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    h_we      = mem_we;
                    h_addr    = mem_addr;
                    h_wdata   = mem_wdata;
                    wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, max_wait);
                    wt_now    = wait_left;
                end else begin
                    check("hold_we", mem_we, h_we);
                    check("hold_addr", mem_addr, h_addr);
                    check("hold_wdata", mem_wdata, h_wdata);
                end
                if (wait_left == 0) begin
                    txn_t t;
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        mem_rdata     = 16'($urandom);
                    end else begin
                        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 16'h0;
                    end
                    t = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, rdata: mem_rdata,
                          cyc: cyc + 1, wt: wt_now, pc: pc_out, cc: cc_out, hlt: halted};
                    txq.push_back(t);
                    in_txn = 1'b0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                    wait_left--;
                end
            end
        end
    end

    function automatic logic [15:0] enc_r(int op, int d, int a, int b);
        return {4'(op), 3'(d), 3'(a), 3'(b), 3'($urandom_range(0, 7))};
    endfunction
    function automatic logic [15:0] enc_i6(int d, int a, int imm);
        return {4'h6, 3'(d), 3'(a), 6'(imm)};
    endfunction
    function automatic logic [15:0] enc_ldi(int d, int imm);
        return {4'h7, 3'(d), 9'(imm)};
    endfunction
    function automatic logic [15:0] enc_br(int c, int off);
        return {4'hA, 4'(c), 8'(off)};
    endfunction

    task automatic put(input logic [15:0] ins);
        mem[wp] = ins;
        wp      = wp + 16'd2;
    endtask

    // Reference arithmetic from the flag definitions, using integer ranges.
    function automatic void alu_model(input int op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] res, output logic [3:0] f);
        int unsigned ua, ub;
        int          sa, sb, s;
        bit          c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; res = 16'h0;
        case (op)
            0, 6: begin
                res = 16'(ua + ub); c = (ua + ub) > 65535;
                s = sa + sb; v = (s > 32767) || (s < -32768);
            end
            1, 11: begin
                res = 16'(ua - ub); c = (ua >= ub);
                s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            default: res = 16'h0;
        endcase
        f = {res[15], res == 16'h0, c, v};
    endfunction

    function automatic bit cond_model(input int c, input logic [3:0] f);
        case (c)
            0: return 1'b1;
            1: return f[2];
            2: return !f[2];
            3: return f[3] != f[0];
            4: return f[3] == f[0];
            5: return f[1];
            6: return !f[1];
            7: return f[3];
            default: return 1'b0;
        endcase
    endfunction

    task automatic get_txn(output txn_t t, output bit ok);
        int n = 0;
        ok = 1'b1;
        t  = '0;
        while (txq.size() == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (txq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL txn_timeout: observed no transfer after %0d cycles, expected one", n);
            ok = 1'b0;
        end else begin
            t = txq.pop_front();
        end
    endtask

    task automatic run_program(output bit ok);
        logic [15:0] r [8];
        logic [15:0] pc, ins, a, b, res;
        logic [3:0]  cc, f;
        txn_t        t, td;
        int          op, rd, ra, rb, prev_cyc, mem_cost, steps;
        bit          prev_valid, done;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        pc = 16'h0; cc = 4'h0; prev_valid = 0; done = 0; steps = 0; mem_cost = 0; prev_cyc = 0;
        ok = 1'b1;
        while (!done && steps < 500) begin
            get_txn(t, ok);
            if (!ok) return;
            check("fetch_we", t.we, 1'b0);
            check("fetch_addr", t.addr, pc);
            check("pc_out", t.pc, pc);
            check("cc_out", t.cc, cc);
            check("halted_run", t.hlt, 1'b0);
            if (prev_valid) check("latency", t.cyc - prev_cyc, 2 + mem_cost + t.wt);
            prev_cyc = t.cyc; prev_valid = 1; mem_cost = 0;
            ins = t.rdata;
            op = ins[15:12]; rd = ins[11:9]; ra = ins[8:6]; rb = ins[5:3];
            a = r[ra]; b = r[rb];
            case (op)
                0, 1, 2, 3, 4, 6, 11: begin
                    alu_model(op, a, (op == 6) ? {{10{ins[5]}}, ins[5:0]} : b, res, f);
                    if (op != 11) r[rd] = res;
                    cc = f;
                    pc = pc + 16'd2;
                end
                5: begin r[rd] = b; pc = pc + 16'd2; end
                7: begin r[rd] = {{7{ins[8]}}, ins[8:0]}; pc = pc + 16'd2; end
                8, 9: begin
                    get_txn(td, ok);
                    if (!ok) return;
                    check("mem_we", td.we, (op == 9));
                    check("mem_addr", td.addr, a);
                    if (op == 9) check("st_wdata", td.wdata, b);
                    else r[rd] = td.rdata;
                    mem_cost = td.wt + 1;
                    pc = pc + 16'd2;
                end
                10: begin
                    int off;
                    off = $signed(ins[7:0]);
                    if (cond_model(ins[11:8], cc)) pc = 16'(int'(pc) + 2 + 2 * off);
                    else pc = pc + 16'd2;
                end
                15: done = 1;
                default: pc = pc + 16'd2;
            endcase
            steps++;
        end
    endtask

    task automatic check_halt();
        repeat (2) @(negedge clk);
        #1;
        check("halted", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("halt_req", mem_req, 1'b0);
        end
        check("halt_no_txn", txq.size(), 0);
    endtask

    task automatic reset_release();
        RESET = 1'b1;
        repeat (3) @(posedge clk);
        txq.delete();
        @(negedge clk);
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_pc", pc_out, 16'h0);
        check("rst_cc", cc_out, 4'h0);
        check("rst_halted", halted, 1'b0);
        @(posedge clk);
        #1;
        RESET = 1'b0;
        @(negedge clk);
        #1;
        check("first_req", mem_req, 1'b1);
        check("first_we", mem_we, 1'b0);
        check("first_addr", mem_addr, 16'h0);
    endtask

    initial begin
        bit ok;
        wp = 16'h0;
        mem[16'h0007] = 16'hBEEF;
        put(enc_ldi(7, 9'h180));
        for (int i = 0; i < 7; i++) put(enc_r(9, 0, 7, i));
        put(enc_ldi(1, 5)); put(enc_ldi(2, 9'h1FD)); put(enc_r(0, 3, 1, 2)); put(enc_r(9, 0, 7, 3));
        put(enc_r(11, 0, 1, 1)); put(enc_br(1, 3));
        repeat (3) put(16'hF000);
        put(enc_br(2, 5)); put(enc_r(5, 6, 0, 3));
        put(enc_r(9, 0, 1, 2)); put(enc_i6(5, 1, 2)); put(enc_r(8, 4, 5, 0)); put(enc_r(9, 0, 7, 4));
        put(enc_ldi(5, 1));
        for (int i = 0; i < 15; i++) put(enc_r(0, 5, 5, 5));
        put(enc_i6(5, 5, 6'h3F)); put(enc_i6(5, 5, 1)); put(enc_r(9, 0, 7, 5));
        put(enc_br(0, 1)); put(enc_br(0, 2)); put(enc_br(0, 8'hFE)); put(16'hF000);
        for (int i = 0; i < 60; i++) begin
            int k, d, a, b;
            k = $urandom_range(0, 11);
            d = $urandom_range(0, 6); a = $urandom_range(0, 7); b = $urandom_range(0, 7);
            case (k)
                6:  put(enc_i6(d, a, $urandom_range(0, 63)));
                7:  put(enc_ldi(d, $urandom_range(0, 511)));
                8:  put(enc_r(8, d, 7, 0));
                9:  put(enc_r(9, 0, 7, b));
                10: put(enc_br($urandom_range(0, 15), $urandom_range(0, 2)));
                11: begin
                    if ($urandom_range(0, 1) == 0) put(enc_r(11, 0, a, b));
                    else put({4'(12 + $urandom_range(0, 2)), 12'($urandom)});
                end
                default: put(enc_r(k, d, a, b));
            endcase
        end
        for (int i = 0; i < 7; i++) put(enc_r(9, 0, 7, i));
        repeat (4) put(16'hF000);

        max_wait = 3;
        reset_release();
        run_program(ok);
        check_halt();

        max_wait = 0;
        @(negedge clk);
        #2;
        RESET = 1'b1;
        #1;
        check("async_halted", halted, 1'b0);
        check("async_pc", pc_out, 16'h0);
        check("async_cc", cc_out, 4'h0);
        reset_release();
        run_program(ok);
        check_halt();

        force_wait = 3;
        reset_release();
        #1;
        check("wait_no_ack", mem_ack, 1'b0);
        RESET = 1'b1;
        #1;
        check("mid_fetch_rst_req", mem_req, 1'b0);
        check("mid_fetch_rst_pc", pc_out, 16'h0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
